parking_gate_arbiter: RTL and testbench

- Sequences the single shared lane barrier and the 15-slot occupancy register of the car-parking system.
- Arbitrates between entry and exit requests and allocates the lowest free slot to arriving cars.
- Releases slots on exit and times out gate openings.
- Its occupancy vector drives the existing occupancy counter and 7-segment path in place of raw slot switches.

---
 rtl/parking_gate_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shared lane barrier sequencing and slot allocation
// Grants entry/exit one at a time, allocates the lowest free slot and times out open gates.
module parking_gate_arbiter #(
  parameter int NUM_SLOTS = 15,
  parameter int TIMEOUT   = 1000,
  parameter int TMR_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry_req,
  input  logic        entry_pass,
  input  logic        exit_req,
  input  logic [3:0]  exit_slot,
  input  logic        exit_pass,
  output logic        entry_ack,
  output logic [3:0]  entry_slot,
  output logic        entry_gate_open,
  output logic        exit_ack,
  output logic        exit_gate_open,
  output logic        exit_err,
  output logic        full,
  output logic [14:0] occupancy,
  output logic [3:0]  free_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  localparam logic [14:0]      SLOT_MASK  = 15'((32'd1 << NUM_SLOTS) - 32'd1);
  localparam logic [3:0]       SLOT_LIMIT = 4'(NUM_SLOTS);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             last_exit, last_exit_nxt;
  logic [3:0]       held_slot, held_slot_nxt;
  logic             entry_pass_q, exit_pass_q;

  logic [14:0] occ_nxt;
  logic [3:0]  entry_slot_nxt;
  logic        entry_ack_nxt, exit_ack_nxt, exit_err_nxt;
  logic        entry_gate_nxt, exit_gate_nxt;

  logic [3:0]  free_slot;
  logic [3:0]  used_cnt;
  logic [15:0] occ_ext;
  logic        exit_valid, entry_elig, pick_entry, pick_exit, timed_out;

  // Lowest-index free slot; scanning downward lets the last write win.
  always_comb begin
    free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) free_slot = 4'(i);
    end
  end

  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < 15; i++) begin
      used_cnt = used_cnt + 4'(occupancy[i]);
    end
  end

  // Extra zero bit keeps slot id 15 a legal index.
  assign occ_ext    = {1'b0, occupancy};
  assign exit_valid = (exit_slot < SLOT_LIMIT) && occ_ext[exit_slot];
  assign entry_elig = entry_req & ~full;
  assign pick_entry = entry_elig & (~exit_req | last_exit);
  assign pick_exit  = exit_req & ~pick_entry;
  assign timed_out  = (timer == TMR_LAST);

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    last_exit_nxt  = last_exit;
    held_slot_nxt  = held_slot;
    occ_nxt        = occupancy;
    entry_slot_nxt = entry_slot;
    entry_ack_nxt  = 1'b0;
    exit_ack_nxt   = 1'b0;
    exit_err_nxt   = 1'b0;
    entry_gate_nxt = entry_gate_open;
    exit_gate_nxt  = exit_gate_open;

    case (state)
      IDLE: begin
        if (pick_entry) begin
          state_nxt      = ENTRY_OPEN;
          entry_ack_nxt  = 1'b1;
          entry_gate_nxt = 1'b1;
          entry_slot_nxt = free_slot;
          occ_nxt        = occupancy | (15'd1 << free_slot);
          timer_nxt      = '0;
          last_exit_nxt  = 1'b0;
        end else if (pick_exit) begin
          last_exit_nxt = 1'b1;
          if (exit_valid) begin
            state_nxt     = EXIT_OPEN;
            exit_ack_nxt  = 1'b1;
            exit_gate_nxt = 1'b1;
            held_slot_nxt = exit_slot;
            timer_nxt     = '0;
          end else begin
            exit_err_nxt = 1'b1;
          end
        end
      end

      ENTRY_OPEN: begin
        timer_nxt = timer + 1'b1;
        if (entry_pass_q) begin
          entry_gate_nxt = 1'b0;
          state_nxt      = IDLE;
        end else if (timed_out) begin
          // Car never came through: give the reserved slot back.
          entry_gate_nxt = 1'b0;
          occ_nxt        = occupancy & ~(15'd1 << entry_slot);
          state_nxt      = IDLE;
        end
      end

      EXIT_OPEN: begin
        timer_nxt = timer + 1'b1;
        if (exit_pass_q) begin
          exit_gate_nxt = 1'b0;
          occ_nxt       = occupancy & ~(15'd1 << held_slot);
          state_nxt     = IDLE;
        end else if (timed_out) begin
          exit_gate_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt      = IDLE;
        entry_gate_nxt = 1'b0;
        exit_gate_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      timer           <= '0;
      last_exit       <= 1'b1;
      held_slot       <= '0;
      entry_pass_q    <= 1'b0;
      exit_pass_q     <= 1'b0;
      occupancy       <= '0;
      entry_slot      <= '0;
      entry_ack       <= 1'b0;
      exit_ack        <= 1'b0;
      exit_err        <= 1'b0;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      full            <= 1'b0;
      free_count      <= SLOT_LIMIT;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      last_exit       <= last_exit_nxt;
      held_slot       <= held_slot_nxt;
      // Pass sensors only count while their own gate is open.
      entry_pass_q    <= entry_pass & (state == ENTRY_OPEN);
      exit_pass_q     <= exit_pass & (state == EXIT_OPEN);
      occupancy       <= occ_nxt & SLOT_MASK;
      entry_slot      <= entry_slot_nxt;
      entry_ack       <= entry_ack_nxt;
      exit_ack        <= exit_ack_nxt;
      exit_err        <= exit_err_nxt;
      entry_gate_open <= entry_gate_nxt;
      exit_gate_open  <= exit_gate_nxt;
      full            <= ((occupancy & SLOT_MASK) == SLOT_MASK);
      free_count      <= SLOT_LIMIT - used_cnt;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed scoreboard bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        entry_req = 1'b0;
  logic        entry_pass = 1'b0;
  logic        exit_req = 1'b0;
  logic [3:0]  exit_slot = '0;
  logic        exit_pass = 1'b0;
  logic        entry_ack;
  logic [3:0]  entry_slot;
  logic        entry_gate_open;
  logic        exit_ack;
  logic        exit_gate_open;
  logic        exit_err;
  logic        full;
  logic [14:0] occupancy;
  logic [3:0]  free_count;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .NUM_SLOTS(15),
    .TIMEOUT  (TIMEOUT),
    .TMR_W    (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .entry_req      (entry_req),
    .entry_pass     (entry_pass),
    .exit_req       (exit_req),
    .exit_slot      (exit_slot),
    .exit_pass      (exit_pass),
    .entry_ack      (entry_ack),
    .entry_slot     (entry_slot),
    .entry_gate_open(entry_gate_open),
    .exit_ack       (exit_ack),
    .exit_gate_open (exit_gate_open),
    .exit_err       (exit_err),
    .full           (full),
    .occupancy      (occupancy),
    .free_count     (free_count)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int          exp_kind_q[$];
  logic [3:0]  exp_slot_q[$];
  logic [14:0] exp_occ = '0;
  logic [3:0]  cur_xslot = '0;
  int          last_wait = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, " occupancy"}, 32'(occupancy), 32'(exp_occ));
    chk({tag, " free_count"}, 32'(free_count), 32'(15 - $countones(exp_occ)));
    chk({tag, " full"}, 32'(full), 32'(exp_occ == 15'h7fff));
  endtask

  task automatic do_reset();
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    entry_pass = 1'b0;
    exit_pass  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset occupancy", 32'(occupancy), 32'h0);
    chk("reset free_count", 32'(free_count), 32'd15);
    chk("reset full", 32'(full), 32'd0);
    chk("reset entry_slot", 32'(entry_slot), 32'd0);
    chk("reset gates", 32'({entry_gate_open, exit_gate_open}), 32'd0);
    chk("reset pulses", 32'({entry_ack, exit_ack, exit_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_occ = '0;
    exp_kind_q.delete();
    exp_slot_q.delete();
  endtask

  task automatic req_entry(input logic [3:0] slot);
    exp_kind_q.push_back(0);
    exp_slot_q.push_back(slot);
    entry_req = 1'b1;
  endtask

  task automatic req_exit(input logic [3:0] slot, input bit ok);
    exp_kind_q.push_back(ok ? 1 : 2);
    cur_xslot = slot;
    exit_slot = slot;
    exit_req  = 1'b1;
  endtask

  task automatic finish_entry(input int pass_delay);
    logic [3:0] s;
    int cnt;
    s = '0;
    if (exp_slot_q.size() > 0) s = exp_slot_q.pop_front();
    chk("entry_slot", 32'(entry_slot), 32'(s));
    chk("entry gate at grant", 32'(entry_gate_open), 32'd1);
    if (pass_delay < 0) begin
      cnt = 0;
      while (entry_gate_open && cnt < TIMEOUT + 20) begin
        @(negedge clk);
        cnt++;
      end
      chk("entry open cycles before timeout", 32'(cnt), 32'(TIMEOUT));
    end else begin
      exp_occ = exp_occ | (15'd1 << s);
      @(negedge clk);
      chk("entry_ack one cycle", 32'(entry_ack), 32'd0);
      repeat (pass_delay - 1) @(negedge clk);
      entry_pass = 1'b1;
      @(negedge clk);
      entry_pass = 1'b0;
      chk("entry gate one cycle after pass", 32'(entry_gate_open), 32'd1);
      @(negedge clk);
      chk("entry gate closed", 32'(entry_gate_open), 32'd0);
    end
    @(negedge clk);
    check_status("after entry");
  endtask

  task automatic finish_exit_ok();
    chk("exit gate at grant", 32'(exit_gate_open), 32'd1);
    @(negedge clk);
    chk("exit_ack one cycle", 32'(exit_ack), 32'd0);
    exit_pass = 1'b1;
    @(negedge clk);
    exit_pass = 1'b0;
    chk("exit gate one cycle after pass", 32'(exit_gate_open), 32'd1);
    @(negedge clk);
    chk("exit gate closed", 32'(exit_gate_open), 32'd0);
    exp_occ = exp_occ & ~(15'd1 << cur_xslot);
    @(negedge clk);
    check_status("after exit");
  endtask

  task automatic finish_exit_err();
    chk("no gate motion on exit_err", 32'({entry_gate_open, exit_gate_open}), 32'd0);
    @(negedge clk);
    chk("exit_err one cycle", 32'(exit_err), 32'd0);
    chk("exit gate stays shut", 32'(exit_gate_open), 32'd0);
    check_status("after exit_err");
  endtask

  // Called one negedge after requests are driven; waits for the grant and checks it against the queue.
  task automatic serve(input bit drop_both, input int pass_delay);
    int kind, want, w;
    w = 0;
    while (!(entry_ack || exit_ack || exit_err) && w < 60) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    kind = entry_ack ? 0 : exit_ack ? 1 : exit_err ? 2 : 3;
    if (entry_ack || drop_both) entry_req = 1'b0;
    if (exit_ack || exit_err || drop_both) exit_req = 1'b0;
    want = -1;
    if (exp_kind_q.size() > 0) want = exp_kind_q.pop_front();
    chk("grant kind", 32'(kind), 32'(want));
    case (kind)
      0:       finish_entry(pass_delay);
      1:       finish_exit_ok();
      2:       finish_exit_err();
      default: ;
    endcase
  endtask

  initial begin
    int acks;

    // 1: first entry after reset
    do_reset();
    req_entry(4'd0);
    @(negedge clk);
    serve(1'b0, 2);
    chk("entry grant latency", 32'(last_wait), 32'd0);

    // 2: fill the lot, then a pending entry must not be granted
    for (int i = 1; i < 15; i++) begin
      req_entry(4'(i));
      @(negedge clk);
      serve(1'b0, 2);
    end
    entry_req = 1'b1;
    acks = 0;
    repeat (50) begin
      @(negedge clk);
      if (entry_ack) acks++;
    end
    chk("no entry grant while full", 32'(acks), 32'd0);

    // 3: exit slot 7 while entry is pending; entry then gets slot 7
    req_exit(4'd7, 1'b1);
    exp_kind_q.push_back(0);
    exp_slot_q.push_back(4'd7);
    @(negedge clk);
    serve(1'b0, 2);
    serve(1'b0, 2);

    // 4: simultaneous requests alternate, entry first after reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        req_entry(4'd0);
        exit_slot = 4'd0;
        cur_xslot = 4'd0;
        exit_req  = 1'b1;
      end else begin
        req_exit(4'd0, 1'b1);
        entry_req = 1'b1;
      end
      @(negedge clk);
      serve(1'b1, 2);
    end

    // 5: invalid slot id and unoccupied slot
    req_entry(4'd0);
    @(negedge clk);
    serve(1'b0, 2);
    req_exit(4'd15, 1'b0);
    @(negedge clk);
    serve(1'b0, 2);
    req_exit(4'd3, 1'b0);
    @(negedge clk);
    serve(1'b0, 2);

    // 6: entry timeout, then reset while a gate is open
    req_entry(4'd1);
    @(negedge clk);
    serve(1'b0, -1);
    req_entry(4'd1);
    @(negedge clk);
    chk("grant before reset", 32'(entry_ack), 32'd1);
    chk("slot before reset", 32'(entry_slot), 32'd1);
    entry_req = 1'b0;
    exp_kind_q.delete();
    exp_slot_q.delete();
    repeat (10) @(negedge clk);
    chk("gate open before reset", 32'(entry_gate_open), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset gates", 32'({entry_gate_open, exit_gate_open}), 32'd0);
    chk("async reset occupancy", 32'(occupancy), 32'h0);
    chk("async reset free_count", 32'(free_count), 32'd15);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
